// File: rtl/wbuart_tx_if.sv
// Wishbone classic slave bundle for the UART transmitter; signal names keep
// the slave-side _i/_o suffixes so both ends read the same as the bus spec.
interface wbuart_tx_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   wb_adr_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW-1:0]   wb_dat_o;
  logic            wb_we_i;
  logic [DW/8-1:0] wb_sel_i;
  logic            wb_ack_o;
  logic            wb_cyc_i;
  logic            wb_stb_i;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wbuart_tx.sv
// Wishbone-slave 8N1 UART transmitter: byte FIFO, programmable bit divisor,
// sticky overflow flag and a level "transmit complete" interrupt.
module wbuart_tx #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 104
) (
  input  logic       wb_clk_i,
  input  logic       wb_reset_ni,
  wbuart_tx_if.slave wb,
  output logic       uart_tx_o,
  output logic       irq_o
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  // Reset asserts asynchronously and releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) rst_sync_q <= 2'b00;
    else              rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [AW-1:0] adr;
  logic [DW-1:0] rdata, dat_q;
  logic          ack_q, req, wr, rd;
  logic [15:0]   divisor_q, status;
  logic          ovf_q, irq_en_q, irq_q;
  logic          push_req, push_ok, pop, st_wr, div_wr, empty, full, busy;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] cnt_q;
  logic [8:0]    lvl9;

  state_e      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] div_q, div_d, baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic        tx_q, tx_d;

  assign adr      = wb.wb_adr_i;
  assign req      = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wr       = req & wb.wb_we_i;
  assign rd       = req & ~wb.wb_we_i;
  assign push_req = wr & (adr[1:0] == 2'd0) & wb.wb_sel_i[0];
  assign st_wr    = wr & (adr[1:0] == 2'd1) & wb.wb_sel_i[0];
  assign div_wr   = wr & (adr[1:0] == 2'd2) & (wb.wb_sel_i[1:0] == 2'b11)
                  & (wb.wb_dat_i[15:0] >= 16'd2);

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == LW'(FIFO_DEPTH));
  assign busy    = (state_q != IDLE);
  assign pop     = (state_q == IDLE) & ~empty;
  // A full FIFO still accepts a write when the transmitter drains a byte that cycle.
  assign push_ok = push_req & (~full | pop);

  assign lvl9   = 9'(cnt_q);
  assign status = {lvl9[7:0], 3'b000, irq_en_q, ovf_q, empty, full, busy};

  always_comb begin
    rdata = '0;
    case (adr[1:0])
      2'd1:    rdata[15:0] = status;
      2'd2:    rdata[15:0] = divisor_q;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      divisor_q <= 16'(DEFAULT_DIV);
      ovf_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ack_q <= req;
      dat_q <= rd ? rdata : '0;
      if (div_wr) divisor_q <= wb.wb_dat_i[15:0];
      if (push_req & full & ~pop)   ovf_q <= 1'b1;
      else if (st_wr & wb.wb_dat_i[3]) ovf_q <= 1'b0;
      if (st_wr) irq_en_q <= wb.wb_dat_i[4];
      irq_q <= empty & ~busy & irq_en_q;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wb.wb_dat_i[7:0];
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Divisor is sampled once per frame so mid-frame writes only affect the next byte.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    div_d   = div_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: if (!empty) begin
        shift_d = mem_q[rptr_q];
        div_d   = divisor_q;
        baud_d  = divisor_q - 16'd1;
        bit_d   = 3'd0;
        state_d = START;
      end
      START: if (baud_q == '0) begin
        baud_d  = div_q - 16'd1;
        state_d = DATA;
      end else baud_d = baud_q - 16'd1;
      DATA: if (baud_q == '0) begin
        baud_d = div_q - 16'd1;
        if (bit_q == 3'd7) state_d = STOP;
        else begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
        end
      end else baud_d = baud_q - 16'd1;
      STOP: if (baud_q == '0) state_d = IDLE;
      else baud_d = baud_q - 16'd1;
      default: state_d = IDLE;
    endcase
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      div_q   <= 16'(DEFAULT_DIV);
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign uart_tx_o   = tx_q;
  assign irq_o       = irq_q;

  logic unused_bits;
  assign unused_bits = ^{adr, wb.wb_dat_i, wb.wb_sel_i, lvl9[8]};
endmodule

// File: tb/tb_wbuart_tx.sv
// Directed bench for wbuart_tx: register map, 8N1 framing, FIFO overflow,
// interrupt timing, ack pulsing and mid-frame reset.
module tb_wbuart_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_tx, irq;
  int   cycn = 0;
  int   checks = 0, passed = 0;

  wbuart_tx_if #(.AW(32), .DW(32)) wb ();

  wbuart_tx #(.AW(32), .DW(32), .FIFO_DEPTH(16), .DEFAULT_DIV(104)) dut (
    .wb_clk_i(clk), .wb_reset_ni(rst_n), .wb(wb), .uart_tx_o(uart_tx), .irq_o(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycn <= cycn + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  task automatic wb_xfer(input logic we, input logic [1:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rdat);
    int n = 0;
    wb.wb_adr_i = {30'd0, a}; wb.wb_dat_i = d; wb.wb_sel_i = s;
    wb.wb_we_i = we; wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    do begin @(posedge clk); #1; n++; end while (wb.wb_ack_o !== 1'b1 && n < 8);
    if (wb.wb_ack_o !== 1'b1) begin
      checks++;
      $display("FAIL wb_ack_timeout adr=%0d: got ack=%b want 1", a, wb.wb_ack_o);
    end
    rdat = wb.wb_dat_o;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, d, s, dummy);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    wb_xfer(1'b0, a, 32'd0, 4'hF, d);
  endtask

  // Waits for a start bit, samples every cycle of the frame plus one idle cycle,
  // and requires each bit to hold exactly div cycles.
  task automatic rx_frame(input int div, input int budget, output logic [7:0] b,
                          output bit ok, output int t0);
    logic smp [0:255];
    int n = 0;
    ok = 1'b1; b = 'x; t0 = -1;
    @(negedge clk);
    while (uart_tx !== 1'b0 && n < budget) begin @(negedge clk); n++; end
    if (uart_tx !== 1'b0) begin ok = 1'b0; return; end
    t0 = cycn;
    for (int c = 0; c <= 10 * div; c++) begin
      if (c > 0) @(negedge clk);
      smp[c] = uart_tx;
    end
    for (int k = 0; k < 10; k++)
      for (int c = k * div; c < (k + 1) * div; c++)
        if (smp[c] !== smp[k * div]) ok = 1'b0;
    if (smp[0] !== 1'b0 || smp[9 * div] !== 1'b1 || smp[10 * div] !== 1'b1) ok = 1'b0;
    for (int k = 1; k <= 8; k++) b[k - 1] = smp[k * div];
  endtask

  task automatic test_reset;
    logic [31:0] r;
    wb.wb_cyc_i = 0; wb.wb_stb_i = 0; wb.wb_we_i = 0;
    wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if ({uart_tx, irq, wb.wb_ack_o} !== 3'b100)
      $display("FAIL reset_held_outputs: got tx/irq/ack=%b want 100", {uart_tx, irq, wb.wb_ack_o});
    else passed++;
    checks++; if (wb.wb_dat_o !== 32'd0)
      $display("FAIL reset_held_dat: got %h want 00000000", wb.wb_dat_o); else passed++;
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    checks++; if ({uart_tx, irq} !== 2'b10)
      $display("FAIL reset_release_line: got tx/irq=%b want 10", {uart_tx, irq}); else passed++;
    rd(2'd1, r);
    checks++; if (r !== 32'h4) $display("FAIL reset_status: got %h want 00000004", r); else passed++;
    rd(2'd2, r);
    checks++; if (r !== 32'd104) $display("FAIL reset_divisor: got %0d want 104", r); else passed++;
  endtask

  task automatic test_single;
    logic [31:0] r, s1, s2;
    logic [7:0] b; bit ok; int t0;
    wr(2'd2, 32'd4, 4'b0011);
    rd(2'd2, r);
    checks++; if (r !== 32'd4) $display("FAIL single_div_readback: got %0d want 4", r); else passed++;
    wr(2'd0, 32'hA5, 4'b0001);
    fork
      rx_frame(4, 20, b, ok, t0);
      begin
        repeat (6) @(posedge clk); #1; rd(2'd1, s1);
        repeat (24) @(posedge clk); #1; rd(2'd1, s2);
      end
    join
    checks++; if ({ok, b} !== {1'b1, 8'hA5})
      $display("FAIL single_frame: got ok=%b byte=%h want ok=1 byte=a5", ok, b); else passed++;
    checks++; if ({s1[0], s2[0]} !== 2'b11)
      $display("FAIL single_busy: got %b want 11", {s1[0], s2[0]}); else passed++;
    repeat (2) @(posedge clk); #1; rd(2'd1, r);
    checks++; if (r !== 32'h4) $display("FAIL single_status_after: got %h want 00000004", r); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] s1, s2;
    logic [7:0] bb [3]; bit okk [3]; int ts [3];
    wr(2'd2, 32'd2, 4'b0011);
    fork
      for (int k = 0; k < 3; k++) rx_frame(2, 40, bb[k], okk[k], ts[k]);
      begin
        wr(2'd0, 32'h00, 4'b0001); wr(2'd0, 32'hFF, 4'b0001); wr(2'd0, 32'h55, 4'b0001);
        rd(2'd1, s1);
        repeat (45) @(posedge clk); #1; rd(2'd1, s2);
      end
    join
    checks++; if ({okk[0], okk[1], okk[2], bb[0], bb[1], bb[2]} !== {3'b111, 24'h00FF55})
      $display("FAIL b2b_bytes: got ok=%b%b%b bytes=%h %h %h want ok=111 bytes=00 ff 55",
               okk[0], okk[1], okk[2], bb[0], bb[1], bb[2]);
    else passed++;
    checks++; if ((ts[1] - ts[0]) != 21 || (ts[2] - ts[1]) != 21)
      $display("FAIL b2b_spacing: got %0d,%0d want 21,21", ts[1] - ts[0], ts[2] - ts[1]);
    else passed++;
    checks++; if (s1 !== 32'h0201) $display("FAIL b2b_level2: got %h want 00000201", s1); else passed++;
    checks++; if (s2 !== 32'h0005) $display("FAIL b2b_empty_last: got %h want 00000005", s2); else passed++;
  endtask

  task automatic test_overflow;
    logic [31:0] s1, s2, r;
    logic [7:0] got [17]; bit okk [17]; int ts [17];
    int bad = 0;
    logic [7:0] v;
    wr(2'd2, 32'd16, 4'b0011);
    fork
      for (int k = 0; k < 17; k++) rx_frame(16, 400, got[k], okk[k], ts[k]);
      begin
        for (int i = 0; i < 18; i++) begin v = 8'(i * 29 + 7); wr(2'd0, {24'd0, v}, 4'b0001); end
        rd(2'd1, s1);
        wr(2'd1, 32'h08, 4'b0001);
        rd(2'd1, s2);
      end
    join
    checks++; if (s1 !== 32'h100B) $display("FAIL ovf_full_status: got %h want 0000100b", s1); else passed++;
    checks++; if (s2 !== 32'h1003) $display("FAIL ovf_cleared: got %h want 00001003", s2); else passed++;
    for (int k = 0; k < 17; k++) begin
      v = 8'(k * 29 + 7);
      if (!okk[k] || got[k] !== v) bad++;
    end
    checks++; if (bad != 0) $display("FAIL ovf_order: got %0d bad frames want 0", bad); else passed++;
    rd(2'd1, r);
    checks++; if (r !== 32'h4) $display("FAIL ovf_drained: got %h want 00000004", r); else passed++;
  endtask

  task automatic test_irq_bus;
    logic [31:0] r;
    logic [7:0] b; bit ok; int t0;
    int bad = 0, dbad = 0;
    logic [5:0] ackpat;
    wr(2'd1, 32'h10, 4'b0001);
    repeat (2) @(posedge clk); #1;
    checks++; if (irq !== 1'b1) $display("FAIL irq_idle_enabled: got %b want 1", irq); else passed++;
    wr(2'd2, 32'd4, 4'b0011);
    wr(2'd0, 32'h3C, 4'b0001);
    fork
      rx_frame(4, 20, b, ok, t0);
      begin
        @(posedge clk);
        repeat (40) begin @(negedge clk); if (irq !== 1'b0) bad++; end
      end
    join
    checks++; if ({ok, b} !== {1'b1, 8'h3C})
      $display("FAIL irq_frame: got ok=%b byte=%h want ok=1 byte=3c", ok, b); else passed++;
    checks++; if (bad != 0) $display("FAIL irq_low_in_frame: got %0d high samples want 0", bad); else passed++;
    @(negedge clk);
    checks++; if (irq !== 1'b1) $display("FAIL irq_after_stop: got %b want 1", irq); else passed++;
    wb.wb_adr_i = 32'd1; wb.wb_we_i = 1'b0; wb.wb_sel_i = 4'hF;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      ackpat[i] = wb.wb_ack_o;
      if (wb.wb_dat_o !== (wb.wb_ack_o ? 32'h14 : 32'h0)) dbad++;
    end
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    checks++; if (ackpat !== 6'b010101) $display("FAIL ack_alternate: got %b want 010101", ackpat); else passed++;
    checks++; if (dbad != 0) $display("FAIL ack_data_gating: got %0d bad want 0", dbad); else passed++;
    wr(2'd2, 32'd1, 4'b0011);
    wr(2'd2, 32'd9, 4'b0001);
    rd(2'd2, r);
    checks++; if (r !== 32'd4) $display("FAIL div_ignored_writes: got %0d want 4", r); else passed++;
    rd(2'd3, r);
    checks++; if (r !== 32'd0) $display("FAIL reserved_read: got %h want 00000000", r); else passed++;
    wr(2'd1, 32'h00, 4'b0001);
    repeat (2) @(posedge clk); #1;
    checks++; if (irq !== 1'b0) $display("FAIL irq_disable: got %b want 0", irq); else passed++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    int n = 0, bad = 0;
    wr(2'd2, 32'd8, 4'b0011);
    wr(2'd0, 32'hF0, 4'b0001); wr(2'd0, 32'h0F, 4'b0001); wr(2'd0, 32'hAA, 4'b0001);
    @(negedge clk);
    while (uart_tx !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    repeat (35) @(negedge clk);
    checks++; if (uart_tx !== 1'b0) $display("FAIL mid_bit3_low: got %b want 0", uart_tx); else passed++;
    rst_n = 1'b0; #1;
    checks++; if (uart_tx !== 1'b1) $display("FAIL mid_async_reset: got %b want 1", uart_tx); else passed++;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    rd(2'd1, r);
    checks++; if (r !== 32'h4) $display("FAIL mid_status: got %h want 00000004", r); else passed++;
    repeat (300) begin @(negedge clk); if (uart_tx !== 1'b1) bad++; end
    checks++; if (bad != 0) $display("FAIL mid_no_residual: got %0d low samples want 0", bad); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_irq_bus();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
